// File: rtl/flex_updown_counter.sv
// flex_updown_counter: parametrised up/down counter over the range 1..rollover_val
// with parallel load, wrap/saturate mode, registered terminal flag and wrap pulse.
//
// Optional feature macro: FLEX_CNT_WRAP_TALLY_EN adds the WRAP_CNT_BITS parameter
// and the wrap_count port, a saturating tally of wrap events.
//
// Ports:
//   clk           rising-edge clock
//   n_rst         asynchronous reset, active low
//   clear         synchronous clear (highest priority)
//   load          synchronous parallel load of load_val
//   load_val      value loaded when load=1
//   count_enable  advance the count this cycle
//   count_up      1 = increment, 0 = decrement
//   saturate      1 = hold at bound, 0 = wrap
//   rollover_val  upper bound of the count range (lower bound is 1)
//   count_out     registered count
//   rollover_flag registered, high while count_out == rollover_val
//   wrap_pulse    registered one-cycle pulse coincident with a wrapped count
//   wrap_count    wrap tally (FLEX_CNT_WRAP_TALLY_EN only)
module flex_updown_counter #(
  parameter int unsigned NUM_CNT_BITS  = 4
`ifdef FLEX_CNT_WRAP_TALLY_EN
  , parameter int unsigned WRAP_CNT_BITS = 8
`endif
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic                    saturate,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse
`ifdef FLEX_CNT_WRAP_TALLY_EN
  , output logic [WRAP_CNT_BITS-1:0] wrap_count
`endif
);

  localparam int unsigned CW = NUM_CNT_BITS;

  logic [CW-1:0] next_count;
  logic          next_flag;
  logic          next_wrap;

  // Next-state: clear > load > count_enable > hold
  always_comb begin
    next_count = count_out;
    next_wrap  = 1'b0;
    if (clear) begin
      next_count = '0;
    end else if (load) begin
      next_count = load_val;
    end else if (count_enable) begin
      if (rollover_val == '0) begin
        next_count = '0;
      end else if (count_up) begin
        if (count_out >= rollover_val) begin
          if (saturate) begin
            next_count = rollover_val;
          end else begin
            next_count = CW'(1);
            next_wrap  = 1'b1;
          end
        end else begin
          next_count = count_out + CW'(1);
        end
      end else begin
        // Down-count bottoms out at 1; a count of 0 (reset/load) also counts as bottom
        if (count_out <= CW'(1)) begin
          if (!saturate) begin
            next_count = rollover_val;
            next_wrap  = 1'b1;
          end
        end else begin
          next_count = count_out - CW'(1);
        end
      end
    end
    next_flag = !clear && (next_count == rollover_val);
  end

  // Single register stage for count and status
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
      wrap_pulse    <= next_wrap;
    end
  end

`ifdef FLEX_CNT_WRAP_TALLY_EN
  // Saturating wrap tally; load leaves it untouched
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wrap_count <= '0;
    end else if (clear) begin
      wrap_count <= '0;
    end else if (next_wrap && (wrap_count != '1)) begin
      wrap_count <= wrap_count + WRAP_CNT_BITS'(1);
    end
  end
`endif

endmodule
